panic_desc_scheduler: RTL and testbench

Descriptor controller sitting behind the packet header parser. Sequences the parser's `desc_req`/`desc_next` query on every new packet and buffers the returned descriptors in two priority-class queues. Dispatches them one at a time to the compute fabric, gated by per-engine credit counters keyed on the first chain hop.

---
 rtl/panic_desc_scheduler_pkg.sv | 22 ++
 rtl/panic_desc_fifo.sv | 59 +++++
 rtl/panic_desc_scheduler.sv | 160 ++++++++++++++++
 tb/tb_panic_desc_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/panic_desc_scheduler_pkg.sv
// Shared descriptor field widths and small helpers for the descriptor scheduler.
package panic_desc_scheduler_pkg;

    // Descriptor field widths (mirror of the parser's descriptor layout)
    localparam int PANIC_DESC_PRIO_SIZE       = 8;
    localparam int PANIC_DESC_CHAIN_SIZE      = 32;
    localparam int PANIC_DESC_CHAIN_ITEM_SIZE = 4;
    localparam int PANIC_DESC_TIME_SIZE       = 32;
    localparam int PANIC_DESC_LEN_SIZE        = 16;
    localparam int PANIC_DESC_FLOW_SIZE       = 8;

    localparam int DROP_W = 16;

    // Saturating add of a small increment to the 16-bit drop counter
    function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] a,
                                                       input logic [1:0] b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + {{(DROP_W-1){1'b0}}, b};
        return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/panic_desc_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty/count.
// The head word is read straight from the array so a write is visible
// at the head one cycle later.
module panic_desc_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [W-1:0]                 wr_data,
    input  logic                         rd_en,
    output logic [W-1:0]                 rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          wr_ok;
    logic          rd_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rd_data = mem[rd_ptr_reg];
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;

    // Storage array write (no reset on contents)
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/panic_desc_scheduler.sv
// Descriptor scheduler: queries the parser once per packet, sorts descriptors
// into a high and a low class queue, and dispatches them through a single
// output register gated by per-engine credits keyed on chain item 0.
module panic_desc_scheduler
    import panic_desc_scheduler_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int NUM_ENGINES = 8,
    parameter int CREDITS     = 4,
    parameter int PRIO_THRESH = 32,
    parameter int PRIO_W      = PANIC_DESC_PRIO_SIZE,
    parameter int CHAIN_W     = PANIC_DESC_CHAIN_SIZE,
    parameter int ITEM_W      = PANIC_DESC_CHAIN_ITEM_SIZE,
    parameter int TIME_W      = PANIC_DESC_TIME_SIZE,
    parameter int LEN_W       = PANIC_DESC_LEN_SIZE,
    parameter int FLOW_W      = PANIC_DESC_FLOW_SIZE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         hdr_valid,
    output logic                         desc_req,
    output logic                         desc_next,
    input  logic [PRIO_W-1:0]            desc_prio,
    input  logic [CHAIN_W-1:0]           desc_chain,
    input  logic [TIME_W-1:0]            desc_time,
    input  logic [LEN_W-1:0]             desc_pk_len,
    input  logic [FLOW_W-1:0]            desc_flow_id,
    output logic                         m_desc_valid,
    input  logic                         m_desc_ready,
    output logic [PRIO_W-1:0]            m_desc_prio,
    output logic [CHAIN_W-1:0]           m_desc_chain,
    output logic [TIME_W-1:0]            m_desc_time,
    output logic [LEN_W-1:0]             m_desc_pk_len,
    output logic [FLOW_W-1:0]            m_desc_flow_id,
    output logic [ITEM_W-1:0]            m_desc_engine,
    input  logic [NUM_ENGINES-1:0]       credit_return,
    output logic [$clog2(DEPTH+1)-1:0]   hi_count,
    output logic [$clog2(DEPTH+1)-1:0]   lo_count,
    output logic [15:0]                  drop_count
);
    localparam int DW        = PRIO_W + CHAIN_W + TIME_W + LEN_W + FLOW_W;
    localparam int CHAIN_LSB = TIME_W + LEN_W + FLOW_W;
    localparam int CRW       = $clog2(CREDITS+1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_QUERY = 1'b1;

    logic [0:0]        state_reg;
    logic [15:0]       drop_reg;
    logic              in_query, to_hi, tgt_full;
    logic              hi_wr, lo_wr, hi_full, lo_full, hi_empty, lo_empty;
    logic [1:0]        drop_inc;
    logic [DW-1:0]     wr_data, hi_head, lo_head;
    logic [ITEM_W-1:0] hi_item0, lo_item0, sel_item0;
    logic              hi_bypass, lo_bypass, hi_elig, lo_elig;
    logic              hi_take, lo_take, load_take, load_en;
    logic              slot_valid_reg;
    logic [DW-1:0]     slot_data_reg;
    logic [NUM_ENGINES-1:0]          credit_avail, hi_hit, lo_hit;
    logic [NUM_ENGINES-1:0][CRW-1:0] credit_reg, credit_next;

    // ---------------- Query side ----------------
    assign in_query  = (state_reg == ST_QUERY);
    assign to_hi     = (32'(desc_prio) < PRIO_THRESH);
    assign tgt_full  = to_hi ? hi_full : lo_full;
    assign hi_wr     = in_query && to_hi && !hi_full;
    assign lo_wr     = in_query && !to_hi && !lo_full;
    assign desc_req  = in_query;
    assign desc_next = in_query && !tgt_full;
    assign wr_data   = {desc_prio, desc_chain, desc_time, desc_pk_len, desc_flow_id};
    // Full-queue drop and a header arriving mid-query each count once
    assign drop_inc  = {1'b0, in_query && tgt_full} + {1'b0, in_query && hdr_valid};

    // Query FSM: one-cycle QUERY per accepted header
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  state_reg <= hdr_valid ? ST_QUERY : ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
        end
    end

    // Saturating drop counter
    always_ff @(posedge clk) begin
        if (!rst_n) drop_reg <= '0;
        else        drop_reg <= sat_add_drop(drop_reg, drop_inc);
    end
    assign drop_count = drop_reg;

    // ---------------- Class queues ----------------
    panic_desc_fifo #(.DEPTH(DEPTH), .W(DW)) u_hi_fifo (
        .clk(clk), .rst_n(rst_n), .wr_en(hi_wr), .wr_data(wr_data), .rd_en(hi_take),
        .rd_data(hi_head), .full(hi_full), .empty(hi_empty), .count(hi_count)
    );

    panic_desc_fifo #(.DEPTH(DEPTH), .W(DW)) u_lo_fifo (
        .clk(clk), .rst_n(rst_n), .wr_en(lo_wr), .wr_data(wr_data), .rd_en(lo_take),
        .rd_data(lo_head), .full(lo_full), .empty(lo_empty), .count(lo_count)
    );

    // ---------------- Head eligibility ----------------
    assign hi_item0  = hi_head[CHAIN_LSB +: ITEM_W];
    assign lo_item0  = lo_head[CHAIN_LSB +: ITEM_W];
    // Item 0 of zero or beyond the engine range needs no credit
    assign hi_bypass = (hi_item0 == '0) || (32'(hi_item0) >= NUM_ENGINES);
    assign lo_bypass = (lo_item0 == '0) || (32'(lo_item0) >= NUM_ENGINES);
    assign hi_elig   = !hi_empty && (hi_bypass || (|hi_hit));
    assign lo_elig   = !lo_empty && (lo_bypass || (|lo_hit));

    assign load_en   = !slot_valid_reg || (slot_valid_reg && m_desc_ready);
    assign hi_take   = load_en && hi_elig;
    assign lo_take   = load_en && !hi_elig && lo_elig;
    assign load_take = hi_take || lo_take;
    assign sel_item0 = hi_take ? hi_item0 : lo_item0;

    // Per-engine credit lookup and next-state (loading and return cancel)
    generate
        for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_eng
            logic inc, dec;
            assign credit_avail[gi] = (credit_reg[gi] != '0);
            assign hi_hit[gi]       = (hi_item0 == ITEM_W'(gi)) && credit_avail[gi];
            assign lo_hit[gi]       = (lo_item0 == ITEM_W'(gi)) && credit_avail[gi];
            assign inc              = credit_return[gi];
            assign dec              = load_take && (gi != 0) && (sel_item0 == ITEM_W'(gi));
            assign credit_next[gi]  =
                (inc && !dec && (credit_reg[gi] != CRW'(CREDITS))) ? credit_reg[gi] + CRW'(1) :
                (dec && !inc && credit_avail[gi])                  ? credit_reg[gi] - CRW'(1) :
                                                                     credit_reg[gi];
        end
    endgenerate

    // Credit counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ENGINES; i++) credit_reg[i] <= CRW'(CREDITS);
        end else begin
            credit_reg <= credit_next;
        end
    end

    // ---------------- Output slot ----------------
    // Single register stage; reloads when empty or when the current entry fires
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_valid_reg <= 1'b0;
            slot_data_reg  <= '0;
        end else if (load_en) begin
            slot_valid_reg <= load_take;
            if (load_take) slot_data_reg <= hi_take ? hi_head : lo_head;
        end
    end

    assign m_desc_valid = slot_valid_reg;
    assign {m_desc_prio, m_desc_chain, m_desc_time, m_desc_pk_len, m_desc_flow_id} = slot_data_reg;
    assign m_desc_engine = m_desc_chain[ITEM_W-1:0];

endmodule

// File: tb/tb_panic_desc_scheduler.sv
// Directed testbench for panic_desc_scheduler.
module tb_panic_desc_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hdr_valid;
    logic        desc_req, desc_next;
    logic [7:0]  desc_prio;
    logic [31:0] desc_chain;
    logic [31:0] desc_time;
    logic [15:0] desc_pk_len;
    logic [7:0]  desc_flow_id;
    logic        m_desc_valid, m_desc_ready;
    logic [7:0]  m_desc_prio;
    logic [31:0] m_desc_chain;
    logic [31:0] m_desc_time;
    logic [15:0] m_desc_pk_len;
    logic [7:0]  m_desc_flow_id;
    logic [3:0]  m_desc_engine;
    logic [7:0]  credit_return;
    logic [3:0]  hi_count, lo_count;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;
    int fire_cnt = 0;
    logic [7:0] flow_log [$];

    panic_desc_scheduler dut (
        .clk(clk), .rst_n(rst_n), .hdr_valid(hdr_valid),
        .desc_req(desc_req), .desc_next(desc_next),
        .desc_prio(desc_prio), .desc_chain(desc_chain), .desc_time(desc_time),
        .desc_pk_len(desc_pk_len), .desc_flow_id(desc_flow_id),
        .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
        .m_desc_prio(m_desc_prio), .m_desc_chain(m_desc_chain), .m_desc_time(m_desc_time),
        .m_desc_pk_len(m_desc_pk_len), .m_desc_flow_id(m_desc_flow_id),
        .m_desc_engine(m_desc_engine), .credit_return(credit_return),
        .hi_count(hi_count), .lo_count(lo_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // Dispatch monitor: one line per fired descriptor
    always @(posedge clk) begin
        if (rst_n && m_desc_valid && m_desc_ready) begin
            fire_cnt++;
            flow_log.push_back(m_desc_flow_id);
            $display("dispatch flow=%0d eng=%0d prio=%0d", m_desc_flow_id, m_desc_engine, m_desc_prio);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hdr_valid = 1'b0;
        credit_return = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One parser transaction: header pulse, then descriptor served in QUERY
    task automatic send(input logic [7:0] prio, input logic [3:0] item0,
                        input logic [7:0] flow, output logic got_next);
        desc_prio    = prio;
        desc_chain   = {28'h5A5A5A5, item0};
        desc_time    = 32'h1000 + {24'h0, flow};
        desc_pk_len  = 16'd64;
        desc_flow_id = flow;
        hdr_valid    = 1'b1;
        tick();
        hdr_valid = 1'b0;
        got_next  = desc_next;
        $display("send flow=%0d prio=%0d item0=%0d next=%0d", flow, prio, item0, got_next);
        tick();
    endtask

    logic gn;
    int   base, nexts;

    initial begin
        rst_n = 1'b0; hdr_valid = 1'b0; credit_return = '0; m_desc_ready = 1'b0;
        desc_prio = '0; desc_chain = '0; desc_time = '0; desc_pk_len = '0; desc_flow_id = '0;

        // Reset state
        do_reset();
        check("rst_valid", m_desc_valid, 1'b0);
        check("rst_req", desc_req, 1'b0);
        check("rst_hi", hi_count, 4'd0);
        check("rst_drop", drop_count, 16'd0);

        // T1: single descriptor latency
        desc_prio = 8'd20; desc_chain = {28'h5A5A5A5, 4'd4}; desc_flow_id = 8'd1;
        desc_time = 32'hCAFE; desc_pk_len = 16'd100;
        hdr_valid = 1'b1;
        tick();                                        // t+1
        hdr_valid = 1'b0;
        check("t1_req", desc_req, 1'b1);
        check("t1_next", desc_next, 1'b1);
        tick();                                        // t+2
        check("t1_valid_t2", m_desc_valid, 1'b0);
        check("t1_hi_t2", hi_count, 4'd1);
        tick();                                        // t+3
        check("t1_valid_t3", m_desc_valid, 1'b1);
        check("t1_engine", m_desc_engine, 4'd4);
        check("t1_prio", m_desc_prio, 8'd20);
        check("t1_time", m_desc_time, 32'hCAFE);
        check("t1_hi_t3", hi_count, 4'd0);
        m_desc_ready = 1'b1;
        tick();
        check("t1_fired", fire_cnt, 1);

        // T2: credit exhaustion on engine 6 and credit return latency
        do_reset();
        m_desc_ready = 1'b1;
        base = fire_cnt;
        for (int i = 0; i < 5; i++) send(8'd20, 4'd6, 8'(40 + i), gn);
        tick(); tick(); tick();
        check("t2_dispatched4", fire_cnt - base, 4);
        check("t2_hi_held", hi_count, 4'd1);
        check("t2_valid_blk", m_desc_valid, 1'b0);
        credit_return = 8'h40;                         // cycle c
        tick();                                        // c+1
        credit_return = '0;
        check("t2_valid_c1", m_desc_valid, 1'b0);
        tick();                                        // c+2
        check("t2_valid_c2", m_desc_valid, 1'b1);
        check("t2_flow5", m_desc_flow_id, 8'd44);
        tick();
        check("t2_dispatched5", fire_cnt - base, 5);

        // T3: high beats low when both are waiting behind a full slot
        do_reset();
        m_desc_ready = 1'b0;
        base = flow_log.size();
        send(8'd20, 4'd0, 8'd30, gn);
        send(8'd50, 4'd0, 8'd31, gn);
        send(8'd20, 4'd4, 8'd32, gn);
        tick();
        check("t3_lo_cnt", lo_count, 4'd1);
        check("t3_hi_cnt", hi_count, 4'd1);
        m_desc_ready = 1'b1;
        tick(); tick(); tick(); tick();
        check("t3_count", flow_log.size() - base, 3);
        if (flow_log.size() - base == 3) begin
            check("t3_order0", flow_log[base], 8'd30);
            check("t3_order1", flow_log[base+1], 8'd32);
            check("t3_order2", flow_log[base+2], 8'd31);
        end

        // T4: blocked high head, bypass low is dispatched (work-conserving)
        do_reset();
        m_desc_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'd20, 4'd6, 8'(50 + i), gn);
        send(8'd20, 4'd6, 8'd54, gn);
        send(8'd50, 4'd0, 8'd55, gn);
        tick(); tick(); tick();
        check("t4_last_flow", flow_log[$], 8'd55);
        check("t4_hi_cnt", hi_count, 4'd1);
        check("t4_lo_cnt", lo_count, 4'd0);
        check("t4_valid", m_desc_valid, 1'b0);

        // Header seen while in QUERY counts as a drop
        m_desc_ready = 1'b0;
        desc_prio = 8'd50; desc_chain = {28'h5A5A5A5, 4'd0}; desc_flow_id = 8'd56;
        hdr_valid = 1'b1;
        tick();                                        // QUERY, second header
        tick();
        hdr_valid = 1'b0;
        check("viol_drop", drop_count, 16'd1);
        tick();
        check("viol_valid", m_desc_valid, 1'b1);
        check("viol_flow", m_desc_flow_id, 8'd56);
        tick(); tick();
        check("stall_flow", m_desc_flow_id, 8'd56);
        check("stall_valid", m_desc_valid, 1'b1);

        // Reset mid-operation (queue non-empty, slot valid, credit[6]=0)
        rst_n = 1'b0;
        tick();
        check("mrst_valid", m_desc_valid, 1'b0);
        check("mrst_hi", hi_count, 4'd0);
        check("mrst_lo", lo_count, 4'd0);
        check("mrst_drop", drop_count, 16'd0);
        check("mrst_req", desc_req, 1'b0);
        rst_n = 1'b1;
        tick();
        // Credits restored to 4; extra returns saturate
        credit_return = 8'h40;
        tick(); tick();
        credit_return = '0;
        m_desc_ready = 1'b1;
        base = fire_cnt;
        for (int i = 0; i < 5; i++) send(8'd20, 4'd6, 8'(60 + i), gn);
        tick(); tick(); tick();
        check("mrst_credit4", fire_cnt - base, 4);
        check("mrst_hi_held", hi_count, 4'd1);

        // T5: queue overflow with a stalled consumer
        do_reset();
        m_desc_ready = 1'b0;
        nexts = 0;
        for (int i = 0; i < 10; i++) begin
            send(8'd20, 4'd0, 8'(70 + i), gn);
            nexts += int'(gn);
        end
        tick(); tick();
        check("t5_nexts", nexts, 9);
        check("t5_last_next", gn, 1'b0);
        check("t5_hi_full", hi_count, 4'd8);
        check("t5_drop", drop_count, 16'd1);
        check("t5_valid", m_desc_valid, 1'b1);
        check("t5_slot_flow", m_desc_flow_id, 8'd70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
